// File: rtl/int_fp_mul_arbiter_pkg.sv
// Shared constants and helpers for the int_fp_mul request arbiter.
package int_fp_mul_arbiter_pkg;

  localparam int NREQ_DEF = 4;
  localparam int IDW_DEF  = 2;

  localparam logic MODE_INT8 = 1'b0;
  localparam logic MODE_FP16 = 1'b1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int k = 0; k < 31; k++) begin
      if ((1 << k) < n) r = k + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/int_fp_mul_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first eligible index at or after ptr, wrapping.
module int_fp_mul_arbiter_rr_arbiter
  import int_fp_mul_arbiter_pkg::*;
#(
  parameter int N  = NREQ_DEF,
  parameter int IW = clog2(N)
) (
  input  logic [N-1:0]  elig,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          grant_any
);

  always_comb begin
    int j;
    // NOTE: every output gets a default before any conditional write, so no latch is inferred.
    j         = 0;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!grant_any && elig[j]) begin
        grant[j]  = 1'b1;
        grant_idx = IW'(j);
        grant_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/int_fp_mul_arbiter.sv
// Shares one int8/fp16 multiplier among NREQ requesters: round-robin issue,
// tag pipeline for ownership, one-entry response register per requester.
module int_fp_mul_arbiter
  import int_fp_mul_arbiter_pkg::*;
#(
  parameter int NREQ    = NREQ_DEF,
  parameter int IDW     = clog2(NREQ),
  parameter int MUL_LAT = 1,
  parameter int ERRW    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ-1:0]      req_mode,
  input  logic [16*NREQ-1:0]   req_a,
  input  logic [16*NREQ-1:0]   req_b,
  output logic                 mul_mode,
  output logic [15:0]          mul_a,
  output logic [15:0]          mul_b,
  input  logic [15:0]          mul_c,
  input  logic                 mul_error,
  output logic [NREQ-1:0]      rsp_valid,
  input  logic [NREQ-1:0]      rsp_ready,
  output logic [16*NREQ-1:0]   rsp_c,
  output logic [NREQ-1:0]      rsp_error,
  output logic                 busy,
  output logic [ERRW-1:0]      err_count,
  input  logic                 err_clr
);

  logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [NREQ-1:0]    pend_q, pend_d;
  logic [NREQ-1:0]    held_q, held_d;
  logic [16*NREQ-1:0] rsp_c_q, rsp_c_d;
  logic [NREQ-1:0]    rsp_error_q, rsp_error_d;
  logic [ERRW-1:0]    err_count_q, err_count_d;
  logic               iv_q, iv_d;
  logic [IDW-1:0]     id_q, id_d;
  logic               mode_q, mode_d;
  logic [15:0]        a_q, a_d, b_q, b_d;

  logic [NREQ-1:0]    elig, grant;
  logic [IDW-1:0]     grant_idx;
  logic               grant_any;

  logic               tail_v, tail_mode, tag_busy;
  logic [IDW-1:0]     tail_id;

  // Blocking uses registered state only, so req_ready never depends on this cycle's capture.
  assign elig = req_valid & ~(pend_q | held_q);

  int_fp_mul_arbiter_rr_arbiter #(.N(NREQ), .IW(IDW)) u_rr (
    .elig      (elig),
    .ptr       (rr_ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  if (MUL_LAT == 0) begin : g_no_tag
    assign tail_v    = iv_q;
    assign tail_id   = id_q;
    assign tail_mode = mode_q;
    assign tag_busy  = 1'b0;
  end else begin : g_tag
    logic [MUL_LAT-1:0] tag_v_q, tag_v_d, tag_mode_q, tag_mode_d;
    logic [IDW-1:0]     tag_id_q [MUL_LAT];
    logic [IDW-1:0]     tag_id_d [MUL_LAT];

    // The mode travels with the tag so the error flag is qualified by the op's own mode.
    always_comb begin
      tag_v_d[0]    = iv_q;
      tag_id_d[0]   = id_q;
      tag_mode_d[0] = mode_q;
      for (int s = 1; s < MUL_LAT; s++) begin
        tag_v_d[s]    = tag_v_q[s-1];
        tag_id_d[s]   = tag_id_q[s-1];
        tag_mode_d[s] = tag_mode_q[s-1];
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        tag_v_q    <= '0;
        tag_mode_q <= '0;
        for (int s = 0; s < MUL_LAT; s++) tag_id_q[s] <= '0;
      end else begin
        tag_v_q    <= tag_v_d;
        tag_mode_q <= tag_mode_d;
        for (int s = 0; s < MUL_LAT; s++) tag_id_q[s] <= tag_id_d[s];
      end
    end

    assign tail_v    = tag_v_q[MUL_LAT-1];
    assign tail_id   = tag_id_q[MUL_LAT-1];
    assign tail_mode = tag_mode_q[MUL_LAT-1];
    assign tag_busy  = |tag_v_q;
  end

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    pend_d      = pend_q;
    held_d      = held_q & ~rsp_ready;
    rsp_c_d     = rsp_c_q;
    rsp_error_d = rsp_error_q;
    err_count_d = err_count_q;
    iv_d        = grant_any;
    id_d        = id_q;
    mode_d      = mode_q;
    a_d         = a_q;
    b_d         = b_q;

    if (grant_any) begin
      pend_d[grant_idx] = 1'b1;
      id_d              = grant_idx;
      mode_d            = req_mode[grant_idx];
      a_d               = req_a[16*grant_idx +: 16];
      b_d               = req_b[16*grant_idx +: 16];
      rr_ptr_d          = (grant_idx == IDW'(NREQ-1)) ? '0 : grant_idx + 1'b1;
    end

    if (tail_v) begin
      pend_d[tail_id]           = 1'b0;
      held_d[tail_id]           = 1'b1;
      rsp_c_d[16*tail_id +: 16] = mul_c;
      rsp_error_d[tail_id]      = mul_error & (tail_mode == MODE_FP16);
    end

    if (err_clr) begin
      err_count_d = '0;
    end else if (tail_v && mul_error && (tail_mode == MODE_FP16) && (err_count_q != '1)) begin
      err_count_d = err_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q    <= '0;
      pend_q      <= '0;
      held_q      <= '0;
      // NOTE: the response data registers are reset too, so rsp_c reads 0 out of reset.
      rsp_c_q     <= '0;
      rsp_error_q <= '0;
      err_count_q <= '0;
      iv_q        <= 1'b0;
      id_q        <= '0;
      mode_q      <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values regardless of statement order.
      rr_ptr_q    <= rr_ptr_d;
      pend_q      <= pend_d;
      held_q      <= held_d;
      rsp_c_q     <= rsp_c_d;
      rsp_error_q <= rsp_error_d;
      err_count_q <= err_count_d;
      iv_q        <= iv_d;
      id_q        <= id_d;
      mode_q      <= mode_d;
      a_q         <= a_d;
      b_q         <= b_d;
    end
  end

  assign req_ready = grant;
  assign mul_mode  = mode_q;
  assign mul_a     = a_q;
  assign mul_b     = b_q;
  assign rsp_valid = held_q;
  assign rsp_c     = rsp_c_q;
  assign rsp_error = rsp_error_q;
  assign busy      = iv_q | tag_busy;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_int_fp_mul_arbiter.sv
// Bench for int_fp_mul_arbiter: multiplier environment, request-level reference model,
// per-cycle compare, and directed scenarios with literal expectations.
module tb_int_fp_mul_arbiter;

  localparam int NREQ    = 4;
  localparam int IDW     = 2;
  localparam int MUL_LAT = 1;
  localparam int ERRW    = 8;
  localparam int CNT_MAX = (1 << ERRW) - 1;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ-1:0]      req_mode = '0;
  logic [16*NREQ-1:0]   req_a = '0;
  logic [16*NREQ-1:0]   req_b = '0;
  logic                 mul_mode;
  logic [15:0]          mul_a, mul_b, mul_c;
  logic                 mul_error;
  logic [NREQ-1:0]      rsp_valid;
  logic [NREQ-1:0]      rsp_ready = '1;
  logic [16*NREQ-1:0]   rsp_c;
  logic [NREQ-1:0]      rsp_error;
  logic                 busy;
  logic [ERRW-1:0]      err_count;
  logic                 err_clr = 1'b0;

  int n_pass = 0;
  int n_total = 0;

  int_fp_mul_arbiter #(.NREQ(NREQ), .IDW(IDW), .MUL_LAT(MUL_LAT), .ERRW(ERRW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_mode  (req_mode),
    .req_a     (req_a),
    .req_b     (req_b),
    .mul_mode  (mul_mode),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_c     (mul_c),
    .mul_error (mul_error),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_c     (rsp_c),
    .rsp_error (rsp_error),
    .busy      (busy),
    .err_count (err_count),
    .err_clr   (err_clr)
  );

  always #5 clk = ~clk;

  // Multiplier behaviour: {error, result}. int8 ops whose A high byte is 0xEE report an error.
  function automatic logic [16:0] mul_fn(input logic m, input logic [15:0] a, input logic [15:0] b);
    int x, y, e;
    logic s;
    logic [21:0] p;
    logic [9:0] mant;
    if (m == 1'b0) begin
      x = $signed(a[7:0]);
      y = $signed(b[7:0]);
      return {a[15:8] == 8'hEE, 16'(x * y)};
    end
    s = a[15] ^ b[15];
    if (a[14:10] == 5'd0 || b[14:10] == 5'd0) return {1'b0, s, 15'd0};
    p = {1'b1, a[9:0]} * {1'b1, b[9:0]};
    e = int'(a[14:10]) + int'(b[14:10]) - 15;
    if (p[21]) begin
      e++;
      mant = p[20:11];
    end else begin
      mant = p[19:10];
    end
    if (e >= 31) return {1'b1, s, 5'h1f, 10'd0};
    if (e <= 0) return {1'b1, s, 15'd0};
    return {1'b0, s, e[4:0], mant};
  endfunction

  logic [16:0] mpipe [MUL_LAT];
  always @(posedge clk) begin
    mpipe[0] <= mul_fn(mul_mode, mul_a, mul_b);
    for (int s = 1; s < MUL_LAT; s++) mpipe[s] <= mpipe[s-1];
  end
  assign mul_c     = mpipe[MUL_LAT-1][15:0];
  assign mul_error = mpipe[MUL_LAT-1][16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: each requester has an outstanding op (due edge) or a held response.
  logic [NREQ-1:0] m_pend = '0, m_held = '0, m_err = '0;
  logic [15:0]     m_c [NREQ];
  logic [15:0]     m_a [NREQ];
  logic [15:0]     m_b [NREQ];
  logic            m_mode [NREQ];
  int              m_due [NREQ];
  int              m_ptr = 0, m_cnt = 0, m_edge = 0, m_iss_idx = 0;
  bit              m_iss = 0;

  function automatic int model_grant();
    int j;
    for (int k = 0; k < NREQ; k++) begin
      j = (m_ptr + k) % NREQ;
      if (req_valid[j] && !m_pend[j] && !m_held[j]) return j;
    end
    return -1;
  endfunction

  task automatic model_clear();
    m_pend = '0; m_held = '0; m_err = '0;
    m_ptr = 0; m_cnt = 0; m_iss = 0;
    for (int i = 0; i < NREQ; i++) m_c[i] = '0;
  endtask

  initial begin
    model_clear();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        model_clear();
      end else begin
        int g, inc;
        logic [16:0] r;
        g = model_grant();
        m_edge++;
        inc = 0;
        for (int i = 0; i < NREQ; i++) if (m_held[i] && rsp_ready[i]) m_held[i] = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
          if (m_pend[i] && m_due[i] == m_edge) begin
            r = mul_fn(m_mode[i], m_a[i], m_b[i]);
            m_pend[i] = 1'b0;
            m_held[i] = 1'b1;
            m_c[i]    = r[15:0];
            m_err[i]  = r[16] & m_mode[i];
            if (m_err[i]) inc++;
          end
        end
        if (err_clr) m_cnt = 0;
        else m_cnt = (m_cnt + inc > CNT_MAX) ? CNT_MAX : m_cnt + inc;
        m_iss = 0;
        if (g >= 0) begin
          m_pend[g] = 1'b1;
          m_due[g]  = m_edge + 1 + MUL_LAT;
          m_mode[g] = req_mode[g];
          m_a[g]    = req_a[16*g +: 16];
          m_b[g]    = req_b[16*g +: 16];
          m_ptr     = (g + 1) % NREQ;
          m_iss     = 1;
          m_iss_idx = g;
        end
      end
    end
  end

  // Per-cycle compare of all outputs against the model, mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        int g;
        logic [NREQ-1:0]    exp_rdy;
        logic [16*NREQ-1:0] exp_c;
        g = model_grant();
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        for (int i = 0; i < NREQ; i++) exp_c[16*i +: 16] = m_c[i];
        check("req_ready", 64'(req_ready), 64'(exp_rdy));
        check("rsp_valid", 64'(rsp_valid), 64'(m_held));
        check("rsp_c", 64'(rsp_c), 64'(exp_c));
        check("rsp_error", 64'(rsp_error), 64'(m_err));
        check("busy", 64'(busy), 64'(|m_pend));
        check("err_count", 64'(err_count), 64'(m_cnt));
        if (m_iss) check("mul_ops", {31'd0, mul_mode, mul_a, mul_b},
                         {31'd0, m_mode[m_iss_idx], m_a[m_iss_idx], m_b[m_iss_idx]});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request and hold it until the handshake edge; returns 1ns after that edge.
  task automatic send(input int i, input logic m, input logic [15:0] a, input logic [15:0] b);
    bit done;
    done = 0;
    req_mode[i] = m;
    req_a[16*i +: 16] = a;
    req_b[16*i +: 16] = b;
    req_valid[i] = 1'b1;
    for (int t = 0; t < 20 && !done; t++) begin
      #1;
      if (req_ready[i]) done = 1;
      step();
    end
    req_valid[i] = 1'b0;
    if (!done) check("send_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    int cnt1;
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cnt1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_req_ready", 64'(req_ready), 64'd0);
    check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_mul", {mul_mode, mul_a, mul_b}, 64'd0);
    rst_n = 1'b1;
    step();

    // Round-robin fairness with everyone requesting and responses drained immediately.
    for (int i = 0; i < NREQ; i++) begin
      req_a[16*i +: 16] = 16'(i + 1);
      req_b[16*i +: 16] = 16'd2;
    end
    req_mode  = '0;
    req_valid = '1;
    for (int c = 0; c < 8; c++) begin
      #1;
      check("rr_order", 64'(req_ready), 64'(1 << (c % NREQ)));
      step();
    end
    req_valid = '0;
    repeat (6) step();

    // Single int8 op on requester 2: 3 * 5.
    rsp_ready[2] = 1'b0;
    req_mode[2] = 1'b0;
    req_a[32 +: 16] = 16'h0003;
    req_b[32 +: 16] = 16'h0005;
    req_valid[2] = 1'b1;
    #1;
    check("int8_ready_same_cycle", 64'(req_ready), 64'b0100);
    send(2, 1'b0, 16'h0003, 16'h0005);
    check("int8_not_yet_edge1", 64'(rsp_valid[2]), 64'd0);
    step();
    check("int8_not_yet_edge2", 64'(rsp_valid[2]), 64'd0);
    step();
    check("int8_rsp_valid", 64'(rsp_valid[2]), 64'd1);
    check("int8_rsp_c", 64'(rsp_c[32 +: 16]), 64'h000F);
    check("int8_rsp_error", 64'(rsp_error[2]), 64'd0);
    rsp_ready[2] = 1'b1;
    step();
    check("int8_rsp_drained", 64'(rsp_valid[2]), 64'd0);
    repeat (2) step();

    // Signed int8 followed immediately by fp16 from another requester.
    send(0, 1'b0, 16'h00FE, 16'h0003);
    send(1, 1'b1, 16'h3C00, 16'h4000);
    step();
    check("signed_rsp_valid", 64'(rsp_valid[0]), 64'd1);
    check("signed_rsp_c", 64'(rsp_c[0 +: 16]), 64'hFFFA);
    step();
    check("fp16_rsp_valid_no_bubble", 64'(rsp_valid[1]), 64'd1);
    check("fp16_rsp_c", 64'(rsp_c[16 +: 16]), 64'h4000);
    check("fp16_rsp_error", 64'(rsp_error[1]), 64'd0);
    repeat (4) step();

    // Requester 1 holds its response; it must not be granted again until it is accepted.
    rsp_ready[1] = 1'b0;
    req_a[16 +: 16] = 16'h0007; req_b[16 +: 16] = 16'h0002; req_mode[1] = 1'b0;
    req_a[48 +: 16] = 16'h0004; req_b[48 +: 16] = 16'h0004; req_mode[3] = 1'b0;
    req_valid[1] = 1'b1;
    req_valid[3] = 1'b1;
    cnt1 = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (req_ready[1]) cnt1++;
      step();
    end
    check("blocked_single_grant", 64'(cnt1), 64'd1);
    check("blocked_rsp_held", 64'(rsp_valid[1]), 64'd1);
    check("blocked_rsp_c", 64'(rsp_c[16 +: 16]), 64'h000E);
    rsp_ready[1] = 1'b1;
    step();
    #1;
    check("resume_rsp_cleared", 64'(rsp_valid[1]), 64'd0);
    check("resume_grant", 64'(req_ready[1]), 64'd1);
    step();
    req_valid = '0;
    repeat (6) step();

    // Error counter: three fp16 overflows and one int8 op with a forced multiplier error.
    send(0, 1'b1, 16'h7800, 16'h7800);
    send(1, 1'b1, 16'h7800, 16'h7800);
    send(2, 1'b1, 16'h7800, 16'h7800);
    send(3, 1'b0, 16'hEE03, 16'h0002);
    repeat (6) step();
    check("err_count_three", 64'(err_count), 64'd3);
    check("fp16_err_flag", 64'(rsp_error[0]), 64'd1);
    check("int8_forced_err_masked", 64'(rsp_error[3]), 64'd0);
    check("int8_forced_err_c", 64'(rsp_c[48 +: 16]), 64'h0006);
    send(0, 1'b1, 16'h7800, 16'h7800);
    step();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("err_clr_priority", 64'(err_count), 64'd0);
    repeat (4) step();

    // Asynchronous reset with two operations in flight.
    send(1, 1'b0, 16'h0002, 16'h0002);
    send(2, 1'b0, 16'h0003, 16'h0003);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("midrst_rsp_c", 64'(rsp_c), 64'd0);
    check("midrst_req_ready", 64'(req_ready), 64'd0);
    check("midrst_mul", {mul_mode, mul_a, mul_b}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      check("postrst_no_stale_rsp", 64'(rsp_valid), 64'd0);
      check("postrst_idle", 64'(busy), 64'd0);
    end
    req_valid = '1;
    #1;
    check("postrst_ptr_zero", 64'(req_ready), 64'b0001);
    step();
    req_valid = '0;
    repeat (6) step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/int_fp_mul_arbiter.md
Name: int_fp_mul_arbiter

Overview:
Round-robin arbiter and sequencer that shares one int_fp_mul datapath (int8 or fp16 multiply, fixed pipeline latency) among NREQ requesters, such as systolic-array PEs or a column of them.
- Accepts operand requests over valid/ready handshakes and registers the winning operands into the multiplier.
- Tracks each in-flight operation's owner with a tag pipeline.
- Returns each result, with its error flag, to the owning requester through a one-entry response holding register with its own valid/ready handshake.
- Keeps a saturating count of fp16 error results.

Parameters:
NREQ, 4, number of requesters (2..8)
IDW, 2, requester-id width, equal to clog2(NREQ)
MUL_LAT, 1, register stages between the multiplier inputs and mul_c/mul_error (0..8; 0 means combinational)
ERRW, 8, width of the error counter

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
req_valid  in  NREQ  per-requester request valid
req_ready  out  NREQ  one-hot grant; a handshake completes when valid and ready are both high at a clock edge
req_mode  in  NREQ  per-requester mode: 1 = fp16, 0 = int8
req_a  in  16*NREQ  operand A, slice i = [16i+15:16i]
req_b  in  16*NREQ  operand B, same slicing as req_a
mul_mode  out  1  mode to the multiplier
mul_a  out  16  operand A to the multiplier
mul_b  out  16  operand B to the multiplier
mul_c  in  16  multiplier result
mul_error  in  1  multiplier overflow/underflow flag
rsp_valid  out  NREQ  per-requester response valid
rsp_ready  in  NREQ  per-requester response accept
rsp_c  out  16*NREQ  held result per requester
rsp_error  out  NREQ  held error flag per requester
busy  out  1  high while any operation is in the issue stage or tag pipeline
err_count  out  ERRW  saturating count of fp16 results returned with mul_error=1
err_clr  in  1  synchronous clear of err_count

Behaviour:
- Reset: all registers and outputs are 0 (req_ready, mul_*, rsp_*, busy, err_count); rr_ptr = 0; tag pipeline cleared. Asserting rst_n mid-operation discards in-flight operations and held responses.
- Per-requester state:
  - pend[i] is set by the grant and cleared when its result is captured.
  - held[i] equals rsp_valid[i].
  - blocked[i] = pend[i] | held[i], computed from registered state only.
- Eligibility: elig[i] = req_valid[i] & ~blocked[i].
- Grant:
  - The search starts at rr_ptr and takes the first eligible index, wrapping modulo NREQ.
  - At most one grant per cycle.
  - req_ready is combinational from req_valid and registered state.
  - On a grant to index w, rr_ptr <= (w+1) mod NREQ. Without a grant, rr_ptr holds.
- Issue stage: the register {iv, id, mode, a, b} loads on a grant; otherwise iv <= 0 and the operands hold. mul_mode/mul_a/mul_b come directly from this register.
- Tag pipeline:
  - MUL_LAT stages of {v, id}, fed from {iv, id}.
  - The tail is the last stage, or the issue register when MUL_LAT = 0.
  - When tail v = 1, at the next edge: capture mul_c into rsp_c[id]; capture mul_error & mode into rsp_error[id] (error is always 0 for int8); set rsp_valid[id]; clear pend[id].
- Latency: a handshake at edge k gives rsp_valid high after edge k+1+MUL_LAT.
- Throughput: one issue per cycle across requesters. Each requester has at most one outstanding operation.
- Response handshake: rsp_valid[i] & rsp_ready[i] at an edge clears rsp_valid[i]. rsp_c[i] holds its value until the next capture.
- Simultaneous response handshake and new request from the same requester: no grant that cycle. The requester is eligible the following cycle.
- A result capture and a response handshake never target the same index in one cycle, because pend and held are mutually exclusive.
- Mode mixing: int8 and fp16 operations may be interleaved back-to-back with no drain or bubble.
- busy = iv | OR of tag v.
- err_count:
  - Increments on each capture where mul_error & mode = 1, and saturates at all ones.
  - err_clr has priority over an increment in the same cycle.

Decomposition:
- Shared package: NREQ/IDW defaults, the MODE_INT8=0 / MODE_FP16=1 constants, and a clog2 function.
- One natural sub-module, rr_arbiter (parameter N): inputs elig and ptr; outputs one-hot grant, grant index, and a any-grant flag. It is purely combinational.
- The pointer register stays in int_fp_mul_arbiter.

Test Plan:
- All tests use a bench model of the multiplier with exactly MUL_LAT register stages.
- Single int8 op, NREQ=4, MUL_LAT=1: requester 2 sends mode=0, a=0x0003, b=0x0005 -> req_ready[2] same cycle; rsp_valid[2] rises 2 edges after the handshake with rsp_c[2]=0x000F and rsp_error[2]=0.
- Signed int8: a=0x00FE, b=0x0003, mode=0 -> rsp_c=0xFFFA, error=0. Then fp16 a=0x3C00, b=0x4000 on the very next cycle -> rsp_c=0x4000 with no bubble.
- Round-robin fairness: all 4 requesters hold valid with rsp_ready=1 -> grants in order 0,1,2,3,0,1...; never two grants in one cycle; every requester is served within 4 cycles.
- Blocking: requester 1 holds rsp_ready=0 and keeps req_valid=1 -> no second grant to 1 while rsp_valid[1]=1. Grants resume the cycle after the rsp handshake; the others are unaffected.
- Error counter: three fp16 ops 0x7800*0x7800 (mul_error=1) plus one int8 op with the model forcing mul_error=1 -> err_count=3. err_clr pulsed together with an error capture -> err_count=0.
- Reset mid-flight: assert rst_n low with 2 ops in the pipeline -> all outputs 0, busy=0, rr_ptr=0, and no stale rsp_valid after release.
